// File: rtl/whack_a_mole_core.sv
// Whack-a-mole game engine: lights one pseudo-random mole at a time, scores
// a hit when the matching switch toggles before the mole times out, and
// tracks lives, rounds and an optional shrinking time window.
module whack_a_mole_core #(
    parameter int unsigned N_MOLES      = 16,
    parameter int unsigned SCORE_W      = 6,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned ROUNDS       = 32,
    parameter int unsigned TIMEOUT_INIT = 100_000_000,
    parameter int unsigned TIMEOUT_STEP = 5_000_000,
    parameter int unsigned TIMEOUT_MIN  = 20_000_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] LED,
    output logic [SCORE_W-1:0] score_count,
    output logic [3:0]         lives_left,
    output logic               playing,
    output logic               game_over,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam int unsigned        IDX_W      = $clog2(N_MOLES);
    localparam int unsigned        RND_W      = $clog2(ROUNDS + 1);
    localparam logic [RND_W-1:0]   LAST_ROUND = RND_W'(ROUNDS);
    localparam logic [31:0]        T_INIT     = 32'(TIMEOUT_INIT);
    localparam logic [31:0]        T_STEP     = 32'(TIMEOUT_STEP);
    localparam logic [31:0]        T_MIN      = 32'(TIMEOUT_MIN);
    // Stepping down is allowed only while the result stays at or above the floor.
    localparam logic [32:0]        T_RAMP_THR = 33'(TIMEOUT_MIN) + 33'(TIMEOUT_STEP);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [N_MOLES-1:0] ONE_HOT_0  = N_MOLES'(1);

    typedef enum logic [1:0] {IDLE, PICK, ACTIVE, DONE} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [IDX_W-1:0]   prev_idx;
    logic [N_MOLES-1:0] sw_prev;
    logic [RND_W-1:0]   round;
    logic [31:0]        cur_timeout;
    logic [31:0]        timer;

    logic [15:0]        lfsr_next;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_MOLES-1:0] toggle;
    logic               wrong;
    logic               scored;
    logic               missed;
    logic [RND_W-1:0]   round_next;
    logic [31:0]        ramped_timeout;

    // Next-LFSR value, mole choice and ACTIVE-state decision terms.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        lfsr_next      = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        pick_idx       = lfsr[IDX_W-1:0];
        if (pick_idx == prev_idx) begin
            pick_idx = pick_idx + 1'b1;
        end
        toggle         = sw ^ sw_prev;
        // LED holds the lit mole while ACTIVE, so it doubles as the hit mask.
        wrong          = |(toggle & ~LED);
        scored         = !wrong && |(toggle & LED);
        missed         = wrong || (!scored && timer == '0);
        round_next     = round + 1'b1;
        ramped_timeout = ({1'b0, cur_timeout} >= T_RAMP_THR) ? cur_timeout - T_STEP : T_MIN;
    end

    // Game FSM with all outputs registered on the decision edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            LED         <= '0;
            score_count <= '0;
            lives_left  <= '0;
            round       <= '0;
            cur_timeout <= T_INIT;
            timer       <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            lfsr        <= LFSR_SEED;
            prev_idx    <= '0;
            // NOTE: sw_prev loads the live switches so positions held through reset never look like toggles.
            sw_prev     <= sw;
        end else begin
            sw_prev    <= sw;
            lfsr       <= lfsr_next;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    LED <= '0;
                    if (start) begin
                        score_count <= '0;
                        lives_left  <= 4'(LIVES);
                        round       <= '0;
                        cur_timeout <= T_INIT;
                        state       <= PICK;
                    end
                end
                PICK: begin
                    LED      <= ONE_HOT_0 << pick_idx;
                    prev_idx <= pick_idx;
                    timer    <= cur_timeout - 1'b1;
                    state    <= ACTIVE;
                end
                ACTIVE: begin
                    if (scored || missed) begin
                        LED   <= '0;
                        round <= round_next;
                        if (scored) begin
                            hit_pulse <= 1'b1;
                            if (score_count != SCORE_MAX) begin
                                score_count <= score_count + 1'b1;
                            end
                            if (TIMEOUT_STEP != 0) begin
                                cur_timeout <= ramped_timeout;
                            end
                        end else begin
                            miss_pulse <= 1'b1;
                            lives_left <= lives_left - 1'b1;
                        end
                        if ((missed && lives_left == 4'd1) || round_next == LAST_ROUND) begin
                            state <= DONE;
                        end else begin
                            state <= PICK;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
            endcase
        end
    end

    assign playing   = (state == PICK) || (state == ACTIVE);
    assign game_over = (state == DONE);

endmodule

// File: tb/tb_whack_a_mole_core.sv
// Directed bench for whack_a_mole_core: three instances (base, ramp,
// narrow score) share clock and reset; a reference LFSR predicts each mole.
module tb_whack_a_mole_core;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b, start_c;
    logic [15:0] sw_a, sw_b, sw_c;
    logic [15:0] led_a, led_b, led_c;
    logic [5:0]  score_a, score_b;
    logic [1:0]  score_c;
    logic [3:0]  lives_a, lives_b, lives_c;
    logic        playing_a, playing_b, playing_c;
    logic        over_a, over_b, over_c;
    logic        hit_a, hit_b, hit_c;
    logic        miss_a, miss_b, miss_c;

    whack_a_mole_core #(.N_MOLES(16), .SCORE_W(6), .LIVES(3), .ROUNDS(4), .TIMEOUT_INIT(8),
                        .TIMEOUT_STEP(0), .TIMEOUT_MIN(8), .LFSR_SEED(SEED)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sw(sw_a), .LED(led_a),
        .score_count(score_a), .lives_left(lives_a), .playing(playing_a),
        .game_over(over_a), .hit_pulse(hit_a), .miss_pulse(miss_a));

    whack_a_mole_core #(.N_MOLES(16), .SCORE_W(6), .LIVES(3), .ROUNDS(4), .TIMEOUT_INIT(8),
                        .TIMEOUT_STEP(2), .TIMEOUT_MIN(4), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sw(sw_b), .LED(led_b),
        .score_count(score_b), .lives_left(lives_b), .playing(playing_b),
        .game_over(over_b), .hit_pulse(hit_b), .miss_pulse(miss_b));

    whack_a_mole_core #(.N_MOLES(16), .SCORE_W(2), .LIVES(6), .ROUNDS(6), .TIMEOUT_INIT(8),
                        .TIMEOUT_STEP(0), .TIMEOUT_MIN(8), .LFSR_SEED(SEED)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .sw(sw_c), .LED(led_c),
        .score_count(score_c), .lives_left(lives_c), .playing(playing_c),
        .game_over(over_c), .hit_pulse(hit_c), .miss_pulse(miss_c));

    // Reference Galois LFSR; m_lfsr_d1 is the value the design used during the previous cycle.
    logic [15:0] m_lfsr, m_lfsr_d1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        m_lfsr    <= reset ? SEED : lfsr_step(m_lfsr);
        m_lfsr_d1 <= m_lfsr;
    end

    int          vectors    = 0;
    int          miscompares = 0;
    logic [3:0]  m_prev   [3];
    logic [15:0] last_led [3];

    function automatic logic [15:0] led_of(input int d);
        case (d)
            0:       return led_a;
            1:       return led_b;
            default: return led_c;
        endcase
    endfunction

    function automatic logic [5:0] score_of(input int d);
        case (d)
            0:       return score_a;
            1:       return score_b;
            default: return {4'b0000, score_c};
        endcase
    endfunction

    function automatic logic [3:0] lives_of(input int d);
        case (d)
            0:       return lives_a;
            1:       return lives_b;
            default: return lives_c;
        endcase
    endfunction

    function automatic logic hit_of(input int d);
        case (d)
            0:       return hit_a;
            1:       return hit_b;
            default: return hit_c;
        endcase
    endfunction

    function automatic logic miss_of(input int d);
        case (d)
            0:       return miss_a;
            1:       return miss_b;
            default: return miss_c;
        endcase
    endfunction

    function automatic logic over_of(input int d);
        case (d)
            0:       return over_a;
            1:       return over_b;
            default: return over_c;
        endcase
    endfunction

    function automatic logic playing_of(input int d);
        case (d)
            0:       return playing_a;
            1:       return playing_b;
            default: return playing_c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic flip(input int d, input logic [15:0] mask);
        case (d)
            0:       sw_a = sw_a ^ mask;
            1:       sw_b = sw_b ^ mask;
            default: sw_c = sw_c ^ mask;
        endcase
    endtask

    task automatic pulse_start(input int d);
        case (d)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    // Waits (bounded) for the next mole and checks it against the reference choice.
    task automatic wait_led(input int d, input string tag, output logic [3:0] idx);
        int         n;
        logic [3:0] e;
        n = 0;
        while (led_of(d) == 16'h0000 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_dark_gap"}, n, 1);
        e = m_lfsr_d1[3:0];
        if (e == m_prev[d]) e = e + 4'd1;
        m_prev[d] = e;
        idx = e;
        check({tag, "_pick"}, led_of(d), 16'h0001 << e);
        if (last_led[d] != 16'h0000) check({tag, "_no_repeat"}, led_of(d) != last_led[d], 1);
        last_led[d] = led_of(d);
    endtask

    // Counts lit cycles from the first lit sample until the mole goes dark.
    task automatic count_lit(input int d, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (led_of(d) != 16'h0000 && n < 40);
    endtask

    initial begin
        logic [3:0] idx;
        logic [3:0] nxt;
        int         n;
        int         t_exp [3];

        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        sw_a    = 16'hFFFF;
        sw_b    = 16'hFFFF;
        sw_c    = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            m_prev[i]   = 4'd0;
            last_led[i] = 16'h0000;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_led", led_a, 16'h0000);
        check("rst_score", score_a, 0);
        check("rst_lives", lives_a, 0);
        check("rst_playing", playing_a, 0);
        check("rst_game_over", over_a, 0);
        check("rst_hit", hit_a, 0);
        check("rst_miss", miss_a, 0);

        // Game A1: every mole hit two cycles after it lights; start mid-mole is ignored.
        pulse_start(0);
        check("a1_lives_init", lives_a, 3);
        check("a1_playing", playing_a, 1);
        check("a1_pick_dark", led_a, 16'h0000);
        for (int r = 0; r < 4; r++) begin
            wait_led(0, "a1", idx);
            if (r == 0) begin
                start_a = 1'b1;
                tick();
                start_a = 1'b0;
                check("a1_start_ignored", led_a, 16'h0001 << idx);
            end else begin
                tick();
            end
            flip(0, 16'h0001 << idx);
            tick();
            check("a1_hit_pulse", hit_a, 1);
            check("a1_no_miss", miss_a, 0);
            check("a1_score", score_a, r + 1);
            check("a1_led_off", led_a, 16'h0000);
        end
        check("a1_game_over", over_a, 1);
        check("a1_not_playing", playing_a, 0);
        check("a1_lives_final", lives_a, 3);
        tick();
        check("a1_done_hold_score", score_a, 4);
        check("a1_done_led", led_a, 16'h0000);

        // Game A2 (restart from DONE): no input, every mole times out after 8 cycles.
        pulse_start(0);
        check("a2_score_cleared", score_a, 0);
        check("a2_lives_init", lives_a, 3);
        for (int r = 0; r < 3; r++) begin
            wait_led(0, "a2", idx);
            count_lit(0, n);
            check("a2_lit_cycles", n, 8);
            check("a2_miss_pulse", miss_a, 1);
            check("a2_no_hit", hit_a, 0);
            check("a2_lives", lives_a, 2 - r);
        end
        check("a2_game_over", over_a, 1);
        check("a2_score_final", score_a, 0);

        // Game B: hits in the last lit cycle show windows 8, 6, 4, then the floor 4.
        t_exp[0] = 8;
        t_exp[1] = 6;
        t_exp[2] = 4;
        pulse_start(1);
        for (int r = 0; r < 3; r++) begin
            wait_led(1, "b", idx);
            repeat (t_exp[r] - 1) tick();
            check("b_lit_until_last", led_b, 16'h0001 << idx);
            flip(1, 16'h0001 << idx);
            tick();
            check("b_last_cycle_hit", hit_b, 1);
            check("b_led_off", led_b, 16'h0000);
        end
        wait_led(1, "b", idx);
        count_lit(1, n);
        check("b_floor_cycles", n, 4);
        check("b_miss_pulse", miss_b, 1);
        check("b_round_limit_done", over_b, 1);
        check("b_score", score_b, 3);
        check("b_lives", lives_b, 2);

        // Game C: six hits into a two-bit score saturate at 3.
        pulse_start(2);
        for (int r = 0; r < 6; r++) begin
            wait_led(2, "c", idx);
            tick();
            flip(2, 16'h0001 << idx);
            tick();
            check("c_hit_pulse", hit_c, 1);
            check("c_score", score_c, (r + 1 > 3) ? 3 : r + 1);
        end
        check("c_game_over", over_c, 1);
        check("c_lives", lives_c, 6);

        // Game A3: lit switch and its neighbour toggle together -> wrong-switch miss.
        pulse_start(0);
        wait_led(0, "a3", idx);
        tick();
        nxt = idx + 4'd1;
        flip(0, (16'h0001 << idx) | (16'h0001 << nxt));
        tick();
        check("a3_wrong_miss", miss_a, 1);
        check("a3_wrong_no_hit", hit_a, 0);
        check("a3_lives", lives_a, 2);
        check("a3_score", score_a, 0);

        // Reset during ACTIVE with the switches changed on the reset edge.
        wait_led(0, "a3", idx);
        tick();
        tick();
        reset = 1'b1;
        flip(0, 16'h0F0F);
        tick();
        check("mid_rst_led", led_a, 16'h0000);
        check("mid_rst_playing", playing_a, 0);
        check("mid_rst_hit", hit_a, 0);
        check("mid_rst_miss", miss_a, 0);
        check("mid_rst_lives", lives_a, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_prev[i]   = 4'd0;
            last_led[i] = 16'h0000;
        end
        tick();
        check("post_rst_idle", playing_a, 0);

        // Switch activity while IDLE must not reach the next game.
        flip(0, 16'h00FF);
        tick();
        tick();
        pulse_start(0);
        wait_led(0, "a4", idx);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("a4_no_spurious_miss", miss_a, 0);
            check("a4_still_lit", led_a, 16'h0001 << idx);
        end
        flip(0, 16'h0001 << idx);
        tick();
        check("a4_hit_pulse", hit_a, 1);
        check("a4_score", score_a, 1);
        check("a4_lives", lives_a, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/whack_a_mole_core.md
Name: whack_a_mole_core

Overview:
- Parametrised whack-a-mole game engine. Lights one pseudo-randomly chosen mole LED at a time. Scores a hit when the player toggles the matching switch in either direction within a time window.
- Adds per-mole timeout, lives, wrong-switch penalty, configurable round count and optional difficulty ramp. The existing fixed 16-LED/32-step sequence has none of these.
- Sits between the debounced switch bank and the LED/score display logic on the board top level.

Parameters:
- N_MOLES, 16, number of moles/switches/LEDs. Power of two, 2..32. IDX_W = log2(N_MOLES).
- SCORE_W, 6, width of score_count. Score saturates at 2^SCORE_W-1.
- LIVES, 3, lives at game start, 1..15.
- ROUNDS, 32, moles presented per game; game ends after this many hits+misses.
- TIMEOUT_INIT, 100_000_000, cycles a mole stays lit at game start (>=2).
- TIMEOUT_STEP, 5_000_000, timeout reduction per hit. 0 disables the ramp.
- TIMEOUT_MIN, 20_000_000, floor for the ramped timeout (>=2, <=TIMEOUT_INIT).
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, single-cycle pulse. Begins a game from IDLE or DONE; ignored otherwise.
- sw, input, N_MOLES, debounced, synchronised switch levels.
- LED, output reg, N_MOLES, one-hot active mole; 0 when no mole is lit.
- score_count, output reg, SCORE_W, hits this game.
- lives_left, output reg, 4, remaining lives.
- playing, output, 1, high in PICK/ACTIVE.
- game_over, output, 1, high in DONE.
- hit_pulse, output reg, 1, one-cycle pulse on a hit.
- miss_pulse, output reg, 1, one-cycle pulse on a miss (timeout or wrong switch).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; LED=0; score_count=0; lives_left=0; round=0.
  - cur_timeout=TIMEOUT_INIT; timer=0; pulses=0.
  - lfsr=LFSR_SEED; prev_idx=0.
  - sw_prev loads sw, so switch positions at reset are never seen as toggles.
  - Reset mid-game aborts immediately; no pulse is emitted.
- sw_prev <= sw every cycle. toggle = sw ^ sw_prev, evaluated only in ACTIVE. Toggles in any other state are discarded.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle in all states, so start timing adds entropy.
- States:
  - IDLE: LED=0. On start: score_count=0, lives_left=LIVES, round=0, cur_timeout=TIMEOUT_INIT, then go to PICK.
  - PICK (exactly 1 cycle, LED=0):
    - idx = lfsr[IDX_W-1:0]. If idx==prev_idx, idx = idx+1 mod N_MOLES (no immediate repeats).
    - On exit: LED <= one-hot(idx), prev_idx <= idx, timer <= cur_timeout-1. Next state ACTIVE.
  - ACTIVE, evaluated each cycle in priority order:
    - (a) toggle has any bit set other than idx -> wrong: miss. This applies even if idx also toggled the same cycle.
    - (b) else toggle[idx] set -> hit.
    - (c) else timer==0 -> timeout miss.
    - (d) else timer decrements.
    - A toggle in the cycle where timer==0 still scores as a hit.
  - Outcome (registered on the same edge as the decision):
    - Hit: score_count+1, saturating. hit_pulse=1. If TIMEOUT_STEP>0: cur_timeout = max(cur_timeout-TIMEOUT_STEP, TIMEOUT_MIN).
    - Miss: lives_left-1. miss_pulse=1.
    - Both cases: LED<=0, round+1.
    - Next state DONE if lives_left reaches 0 or round reaches ROUNDS; else PICK.
  - DONE: LED=0. score_count and lives_left hold. start behaves as in IDLE.
- Mole timing: the mole is lit for exactly cur_timeout cycles absent input. LED is dark for exactly 1 cycle (PICK) between moles.
- Latency: a switch edge sampled at edge k is reflected in score_count/lives_left/pulse at edge k+1.
- start during PICK/ACTIVE is ignored.
- Simultaneous final hit and round limit: score is updated, then DONE.

Test Plan:
- N_MOLES=16, TIMEOUT_INIT=8, STEP=0, LIVES=3, ROUNDS=4; reset with sw=16'hFFFF, then start; toggle each lit switch 2 cycles after LED lights -> score_count=4, lives_left=3, 4 hit_pulses, game_over=1, LED=0.
- Same config, no switch activity -> each mole lit exactly 8 cycles, 1 dark cycle between moles; 3 miss_pulses; DONE after round 3 with lives_left=0, score_count=0.
- Lit mole idx i; toggle sw[i] and sw[(i+1)%16] in the same cycle -> miss_pulse, lives_left 3->2, score unchanged.
- TIMEOUT_INIT=8, STEP=2, MIN=4: three consecutive hits -> successive mole lit durations 8, 6, 4, then 4.
- Reset asserted mid-ACTIVE with sw differing from the reset-time value afterwards held constant -> LED=0, IDLE, no pulses; next game sees no spurious toggle. Across all games, no two consecutive LED values are equal.
- SCORE_W=2, ROUNDS=6, LIVES=6, all hits -> score_count saturates at 3.
